// File: rtl/me_stage_unit_if.sv
// EX->ME->WB handshake, payload buses and the data SRAM read-return path
// seen by the memory-access stage.
interface me_stage_unit_if #(
  parameter int XLEN     = 32,
  parameter int EX_BUS_W = 71,
  parameter int WB_BUS_W = 70
);
  logic                EX_to_ME_Valid;
  logic [EX_BUS_W-1:0] EX_to_ME_Bus;
  logic                ME_Allow_in;
  logic [XLEN-1:0]     data_sram_rdata;
  logic                ME_to_WB_Valid;
  logic                WB_Allow_in;
  logic [WB_BUS_W-1:0] ME_to_WB_Bus;
  logic [4:0]          ME_dest;

  // ME stage side
  modport slave (
    input  EX_to_ME_Valid, EX_to_ME_Bus, data_sram_rdata, WB_Allow_in,
    output ME_Allow_in, ME_to_WB_Valid, ME_to_WB_Bus, ME_dest
  );

  // surrounding pipeline (EX, SRAM, WB) side
  modport master (
    output EX_to_ME_Valid, EX_to_ME_Bus, data_sram_rdata, WB_Allow_in,
    input  ME_Allow_in, ME_to_WB_Valid, ME_to_WB_Bus, ME_dest
  );
endinterface

// File: rtl/me_stage_unit.sv
// Memory-access pipeline stage. Latches the EX payload, merges the load data
// that returns one cycle after issue, and keeps that data in rdata_hold while
// WB back-pressures (the SRAM read data is only live for one cycle).
module me_stage_unit #(
  parameter int XLEN     = 32,
  parameter int EX_BUS_W = 71,
  parameter int WB_BUS_W = 70
) (
  input  logic             clk,
  input  logic             reset,
  me_stage_unit_if.slave   bus_if
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FRESH = 2'd1,  // first cycle in ME: SRAM read data belongs to us
    S_HELD  = 2'd2   // stalled past first cycle: use rdata_hold
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   alu_q, alu_d;
  logic              res_from_mem_q, res_from_mem_d;
  logic              gr_we_q, gr_we_d;
  logic [4:0]        dest_q, dest_d;
  logic [XLEN-1:0]   rdata_hold_q, rdata_hold_d;

  logic [EX_BUS_W-1:0] ex_bus;
  logic [WB_BUS_W-1:0] wb_bus;
  logic                me_valid;
  logic                allow_in;
  logic                ex_fire;
  logic [XLEN-1:0]     final_result;

  assign ex_bus   = bus_if.EX_to_ME_Bus;
  assign me_valid = (state_q != S_EMPTY);
  assign allow_in = !me_valid || bus_if.WB_Allow_in;
  assign ex_fire  = bus_if.EX_to_ME_Valid && allow_in;

  // next state, payload capture and load-data hold capture
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    alu_d          = alu_q;
    res_from_mem_d = res_from_mem_q;
    gr_we_d        = gr_we_q;
    dest_d         = dest_q;
    rdata_hold_d   = rdata_hold_q;

    unique case (state_q)
      S_EMPTY: begin
        if (bus_if.EX_to_ME_Valid) state_d = S_FRESH;
      end
      S_FRESH: begin
        if (bus_if.WB_Allow_in) begin
          state_d = bus_if.EX_to_ME_Valid ? S_FRESH : S_EMPTY;
        end else begin
          // last chance to grab the SRAM data before it goes away
          state_d      = S_HELD;
          rdata_hold_d = bus_if.data_sram_rdata;
        end
      end
      S_HELD: begin
        if (bus_if.WB_Allow_in)
          state_d = bus_if.EX_to_ME_Valid ? S_FRESH : S_EMPTY;
      end
      default: state_d = S_EMPTY;
    endcase

    if (ex_fire) begin
      pc_d           = ex_bus[70:39];
      alu_d          = ex_bus[38:7];
      res_from_mem_d = ex_bus[6];
      gr_we_d        = ex_bus[5];
      dest_d         = ex_bus[4:0];
    end
  end

  // state and payload registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_EMPTY;
      pc_q           <= '0;
      alu_q          <= '0;
      res_from_mem_q <= 1'b0;
      gr_we_q        <= 1'b0;
      dest_q         <= '0;
      rdata_hold_q   <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      alu_q          <= alu_d;
      res_from_mem_q <= res_from_mem_d;
      gr_we_q        <= gr_we_d;
      dest_q         <= dest_d;
      rdata_hold_q   <= rdata_hold_d;
    end
  end

  // result select; outside FRESH the hold register is used so an empty stage
  // never forwards the (possibly X) raw SRAM bus
  always_comb begin
    final_result = alu_q;
    if (res_from_mem_q)
      final_result = (state_q == S_FRESH) ? bus_if.data_sram_rdata : rdata_hold_q;
  end

  assign wb_bus = {pc_q, final_result, gr_we_q, dest_q};

  assign bus_if.ME_Allow_in    = allow_in;
  assign bus_if.ME_to_WB_Valid = me_valid;
  assign bus_if.ME_to_WB_Bus   = wb_bus;
  assign bus_if.ME_dest        = (me_valid && gr_we_q) ? dest_q : 5'd0;

endmodule

// File: tb/tb_me_stage_unit.sv
// Bench for me_stage_unit: directed vector table, hand-written stall/reset
// sequences, then randomized traffic against an occupancy-based model.
module tb_me_stage_unit;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  me_stage_unit_if u_if ();

  me_stage_unit u_dut (
    .clk    (clk),
    .reset  (reset),
    .bus_if (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ev;
    logic [70:0] bus;
    logic [31:0] rdata;
    logic        wba;
    logic        e_valid;
    logic        e_allow;
    logic [31:0] e_pc;
    logic [31:0] e_final;
    logic [4:0]  e_dest;
  } vec_t;

  vec_t tbl[12];

  function automatic logic [70:0] mk(input logic [31:0] pc, input logic [31:0] alu,
                                     input logic rfm, input logic we, input logic [4:0] d);
    return {pc, alu, rfm, we, d};
  endfunction

  function automatic vec_t v(input logic ev, input logic [70:0] b, input logic [31:0] rd,
                             input logic wba, input logic evl, input logic eal,
                             input logic [31:0] epc, input logic [31:0] efin,
                             input logic [4:0] ed);
    vec_t t;
    t.ev = ev; t.bus = b; t.rdata = rd; t.wba = wba;
    t.e_valid = evl; t.e_allow = eal; t.e_pc = epc; t.e_final = efin; t.e_dest = ed;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [69:0] act, input logic [69:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic ev, input logic [70:0] b, input logic [31:0] rd,
                     input logic wba);
    u_if.EX_to_ME_Valid  = ev;
    u_if.EX_to_ME_Bus    = b;
    u_if.data_sram_rdata = rd;
    u_if.WB_Allow_in     = wba;
  endtask

  // advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // behavioural model: one occupant slot with the load value it saw first
  logic        m_valid, m_first, m_rfm, m_we;
  logic [31:0] m_pc, m_alu, m_ld;
  logic [4:0]  m_dest;

  initial begin
    logic [31:0] fin;
    logic        acc;
    logic [70:0] rb;
    logic [31:0] rrd;
    logic        rev, rwba;

    checks = 0;
    failures = 0;
    reset = 1'b1;
    drv(1'b0, '0, '0, 1'b0);
    #3;
    chk("reset_valid", {69'd0, u_if.ME_to_WB_Valid}, 70'd0);
    chk("reset_allow", {69'd0, u_if.ME_Allow_in}, 70'd1);
    chk("reset_dest",  {65'd0, u_if.ME_dest}, 70'd0);
    chk("reset_bus",   u_if.ME_to_WB_Bus, 70'd0);
    cyc();
    reset = 1'b0;

    // ---- directed table: load, load under 3-cycle stall, ALU ops ----
    tbl[0]  = v(1, mk(32'h1c000010, 32'h100, 1, 1, 5), 32'h0, 1, 0, 1, 0, 0, 0);
    tbl[1]  = v(0, '0, 32'hDEADBEEF, 1, 1, 1, 32'h1c000010, 32'hDEADBEEF, 5);
    tbl[2]  = v(0, '0, 32'h0, 1, 0, 1, 0, 0, 0);
    tbl[3]  = v(1, mk(32'h1c000020, 32'h100, 1, 1, 6), 32'h0, 1, 0, 1, 0, 0, 0);
    tbl[4]  = v(1, mk(32'h1c000024, 32'h42, 0, 1, 7), 32'hDEADBEEF, 0, 1, 0, 32'h1c000020, 32'hDEADBEEF, 6);
    tbl[5]  = v(1, mk(32'h1c000024, 32'h42, 0, 1, 7), 32'h11111111, 0, 1, 0, 32'h1c000020, 32'hDEADBEEF, 6);
    tbl[6]  = v(1, mk(32'h1c000024, 32'h42, 0, 1, 7), 32'h22222222, 0, 1, 0, 32'h1c000020, 32'hDEADBEEF, 6);
    tbl[7]  = v(1, mk(32'h1c000024, 32'h42, 0, 1, 7), 32'h33333333, 1, 1, 1, 32'h1c000020, 32'hDEADBEEF, 6);
    tbl[8]  = v(0, '0, 32'hFFFFFFFF, 1, 1, 1, 32'h1c000024, 32'h42, 7);
    tbl[9]  = v(1, mk(32'h1c000030, 32'h42, 0, 0, 7), 32'hFFFFFFFF, 1, 0, 1, 0, 0, 0);
    tbl[10] = v(0, '0, 32'hFFFFFFFF, 1, 1, 1, 32'h1c000030, 32'h42, 0);
    tbl[11] = v(0, '0, 32'h0, 1, 0, 1, 0, 0, 0);

    for (int i = 0; i < 12; i++) begin
      drv(tbl[i].ev, tbl[i].bus, tbl[i].rdata, tbl[i].wba);
      #3;
      chk($sformatf("tbl%0d_valid", i), {69'd0, u_if.ME_to_WB_Valid}, {69'd0, tbl[i].e_valid});
      chk($sformatf("tbl%0d_allow", i), {69'd0, u_if.ME_Allow_in}, {69'd0, tbl[i].e_allow});
      chk($sformatf("tbl%0d_dest", i),  {65'd0, u_if.ME_dest}, {65'd0, tbl[i].e_dest});
      if (tbl[i].e_valid) begin
        chk($sformatf("tbl%0d_pc", i),    {38'd0, u_if.ME_to_WB_Bus[69:38]}, {38'd0, tbl[i].e_pc});
        chk($sformatf("tbl%0d_final", i), {38'd0, u_if.ME_to_WB_Bus[37:6]},  {38'd0, tbl[i].e_final});
      end
      cyc();
    end

    // ---- back-to-back: three instructions, one per cycle ----
    for (int i = 0; i < 5; i++) begin
      if (i < 3) drv(1'b1, mk(32'h1c000100 + 32'(4*i), 32'h100 + 32'(i), 0, 1, 5'd3), 32'h0, 1'b1);
      else       drv(1'b0, '0, 32'h0, 1'b1);
      #3;
      chk($sformatf("b2b%0d_allow", i), {69'd0, u_if.ME_Allow_in}, 70'd1);
      chk($sformatf("b2b%0d_valid", i), {69'd0, u_if.ME_to_WB_Valid}, {69'd0, (i >= 1 && i <= 3)});
      if (i >= 1 && i <= 3)
        chk($sformatf("b2b%0d_pc", i), {38'd0, u_if.ME_to_WB_Bus[69:38]},
            {38'd0, 32'h1c000100 + 32'(4*(i-1))});
      cyc();
    end

    // ---- bubble: garbage on the bus must not load ----
    for (int i = 0; i < 2; i++) begin
      drv(1'b0, {$urandom, $urandom, 7'($urandom)}, $urandom, 1'b1);
      #3;
      chk($sformatf("bub%0d_valid", i), {69'd0, u_if.ME_to_WB_Valid}, 70'd0);
      chk($sformatf("bub%0d_pc", i), {38'd0, u_if.ME_to_WB_Bus[69:38]}, {38'd0, 32'h1c000108});
      chk($sformatf("bub%0d_wedst", i), {64'd0, u_if.ME_to_WB_Bus[5:0]}, {64'd0, 6'b1_00011});
      cyc();
    end

    // ---- reset mid-stall, then a fresh load must not see the stale hold ----
    drv(1'b1, mk(32'h1c000200, 32'h0, 1, 1, 4), 32'h0, 1'b0);
    cyc();
    drv(1'b0, '0, 32'hAAAA5555, 1'b0);
    #3;
    chk("rst_fresh_final", {38'd0, u_if.ME_to_WB_Bus[37:6]}, {38'd0, 32'hAAAA5555});
    cyc();
    drv(1'b0, '0, 32'h0, 1'b0);
    #3;
    chk("rst_held_final", {38'd0, u_if.ME_to_WB_Bus[37:6]}, {38'd0, 32'hAAAA5555});
    chk("rst_held_allow", {69'd0, u_if.ME_Allow_in}, 70'd0);
    reset = 1'b1;
    #1;
    chk("rst_async_valid", {69'd0, u_if.ME_to_WB_Valid}, 70'd0);
    chk("rst_async_allow", {69'd0, u_if.ME_Allow_in}, 70'd1);
    chk("rst_async_dest",  {65'd0, u_if.ME_dest}, 70'd0);
    chk("rst_async_bus",   u_if.ME_to_WB_Bus, 70'd0);
    cyc();
    reset = 1'b0;
    drv(1'b1, mk(32'h1c000300, 32'h0, 1, 1, 8), 32'h0, 1'b1);
    cyc();
    drv(1'b0, '0, 32'h12345678, 1'b1);
    #3;
    chk("post_rst_valid", {69'd0, u_if.ME_to_WB_Valid}, 70'd1);
    chk("post_rst_final", {38'd0, u_if.ME_to_WB_Bus[37:6]}, {38'd0, 32'h12345678});
    chk("post_rst_dest",  {65'd0, u_if.ME_dest}, 70'd8);
    cyc();
    drv(1'b0, '0, 32'h0, 1'b1);
    #3;
    chk("post_rst_drain", {69'd0, u_if.ME_to_WB_Valid}, 70'd0);

    // ---- randomized traffic vs model ----
    reset = 1'b1;
    #1;
    reset = 1'b0;
    m_valid = 0; m_first = 0; m_rfm = 0; m_we = 0;
    m_pc = 0; m_alu = 0; m_ld = 0; m_dest = 0;
    cyc();
    for (int n = 0; n < 400; n++) begin
      rev  = ($urandom_range(3) != 0);
      rwba = ($urandom_range(2) != 0);
      rb   = {$urandom, $urandom, 7'($urandom)};
      rrd  = $urandom;
      drv(rev, rb, rrd, rwba);
      #3;
      chk("rnd_valid", {69'd0, u_if.ME_to_WB_Valid}, {69'd0, m_valid});
      chk("rnd_allow", {69'd0, u_if.ME_Allow_in}, {69'd0, (!m_valid || rwba)});
      chk("rnd_dest",  {65'd0, u_if.ME_dest}, {65'd0, (m_valid && m_we) ? m_dest : 5'd0});
      chk("rnd_pcwe",  {u_if.ME_to_WB_Bus[69:38], 32'd0, u_if.ME_to_WB_Bus[5:0]},
                       {m_pc, 32'd0, m_we, m_dest});
      if (m_valid) begin
        fin = !m_rfm ? m_alu : (m_first ? rrd : m_ld);
        chk("rnd_final", {38'd0, u_if.ME_to_WB_Bus[37:6]}, {38'd0, fin});
      end
      acc = rev && (!m_valid || rwba);
      @(posedge clk);
      if (acc) begin
        m_valid = 1; m_first = 1;
        m_pc = rb[70:39]; m_alu = rb[38:7]; m_rfm = rb[6]; m_we = rb[5]; m_dest = rb[4:0];
      end else if (m_valid && rwba) begin
        m_valid = 0;
      end else if (m_valid) begin
        if (m_first) m_ld = rrd;
        m_first = 0;
      end
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
